// File: rtl/flag_sequencer_pkg.sv
// Shared encodings and defaults for the flag sequencer and its button conditioning.
// Lives next to the flag colour definitions so every flag-related file sees one set.
package flag_sequencer_pkg;

   localparam int NUM_FLAGS_DEF = 24;
   localparam int V_ACTIVE_DEF  = 480;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WIPE = 1'b1;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_FWD  = 2'd1,
      DIR_BACK = 2'd2
   } dir_t;

   // Two simultaneous edges cancel rather than picking a winner.
   function automatic dir_t decode_req(input logic nxt_pulse, input logic prv_pulse);
      dir_t d;
      d = DIR_NONE;
      if (nxt_pulse && !prv_pulse)
         d = DIR_FWD;
      else if (prv_pulse && !nxt_pulse)
         d = DIR_BACK;
      return d;
   endfunction

endpackage

// File: rtl/flag_sequencer_btn_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector; a held button
// yields a single one-cycle pulse.
module btn_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);

   logic sync_p0;
   logic sync_p1;
   logic sync_p2;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         sync_p2 <= 1'b0;
      end else begin
         sync_p0 <= btn;
         sync_p1 <= sync_p0;
         sync_p2 <= sync_p1;
      end
   end

   // Pulse is combinational so the sequencer consumes it two edges after capture.
   assign pulse = sync_p1 & ~sync_p2;

endmodule

// File: rtl/flag_sequencer.sv
// Selects the displayed pride flag and transitions between flags with a
// top-to-bottom wipe driven by button edges or an auto-advance dwell timer.
import flag_sequencer_pkg::*;

module flag_sequencer #(
   parameter int NUM_FLAGS    = NUM_FLAGS_DEF,
   parameter int SEL_W        = 5,
   parameter int DWELL_FRAMES = 180,
   parameter int WIPE_STEP    = 16,
   parameter int V_ACTIVE     = V_ACTIVE_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_tick,
   input  logic [9:0]       pix_y,
   input  logic             btn_next,
   input  logic             btn_prev,
   input  logic             auto_en,
   output logic [SEL_W-1:0] flag_sel,
   output logic [SEL_W-1:0] flag_cur,
   output logic             busy
);

   localparam int DW_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
   localparam logic [SEL_W-1:0] LAST_FLAG  = SEL_W'(NUM_FLAGS - 1);
   localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_FRAMES - 1);
   localparam logic [10:0]      STEP_11    = 11'(WIPE_STEP);
   localparam logic [10:0]      VACT_11    = 11'(V_ACTIVE);
   localparam logic [9:0]       STEP_10    = 10'(WIPE_STEP);

   logic             pulse_next;
   logic             pulse_prev;
   dir_t             req;
   dir_t             pend_eff;
   dir_t             pending;
   logic [0:0]       state;
   logic [SEL_W-1:0] cur;
   logic [SEL_W-1:0] nxt;
   logic [9:0]       wipe_row;
   logic [DW_W-1:0]  dwell;
   logic             wipe_done;

   function automatic logic [SEL_W-1:0] step_flag(input logic [SEL_W-1:0] idx,
                                                  input dir_t              dir);
      logic [SEL_W-1:0] r;
      r = idx;
      if (dir == DIR_FWD)
         r = (idx == LAST_FLAG) ? '0 : idx + SEL_W'(1);
      else if (dir == DIR_BACK)
         r = (idx == '0) ? LAST_FLAG : idx - SEL_W'(1);
      return r;
   endfunction

   btn_sync_edge u_sync_next (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_next),
      .pulse (pulse_next)
   );

   btn_sync_edge u_sync_prev (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_prev),
      .pulse (pulse_prev)
   );

   assign req       = decode_req(pulse_next, pulse_prev);
   // A request arriving on the completion cycle is newer than the stored one.
   assign pend_eff  = (req != DIR_NONE) ? req : pending;
   assign wipe_done = ({1'b0, wipe_row} + STEP_11) >= VACT_11;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cur      <= '0;
         nxt      <= '0;
         wipe_row <= '0;
         dwell    <= '0;
         pending  <= DIR_NONE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req != DIR_NONE) begin
                  nxt      <= step_flag(cur, req);
                  wipe_row <= '0;
                  dwell    <= '0;
                  state    <= ST_WIPE;
               end else if (!auto_en) begin
                  dwell <= '0;
               end else if (frame_tick) begin
                  if (dwell == DWELL_LAST) begin
                     nxt      <= step_flag(cur, DIR_FWD);
                     wipe_row <= '0;
                     dwell    <= '0;
                     state    <= ST_WIPE;
                  end else begin
                     dwell <= dwell + DW_W'(1);
                  end
               end
            end
            ST_WIPE: begin
               if (req != DIR_NONE)
                  pending <= req;
               if (frame_tick) begin
                  if (wipe_done) begin
                     cur      <= nxt;
                     wipe_row <= '0;
                     pending  <= DIR_NONE;
                     if (pend_eff != DIR_NONE) begin
                        nxt <= step_flag(nxt, pend_eff);
                     end else begin
                        state <= ST_IDLE;
                        dwell <= '0;
                     end
                  end else begin
                     wipe_row <= wipe_row + STEP_10;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy     = (state == ST_WIPE);
   assign flag_cur = cur;
   assign flag_sel = (busy && (pix_y < wipe_row)) ? nxt : cur;

endmodule

// File: tb/tb_flag_sequencer.sv
// Directed bench for flag_sequencer: button stepping, wrap-around, wipe
// boundary, chained requests, auto dwell and reset abort.
module tb_flag_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_tick = 1'b0;
   logic [9:0] pix_y = 10'd0;
   logic       btn_next = 1'b0;
   logic       btn_prev = 1'b0;
   logic       auto_en = 1'b0;
   logic [4:0] flag_sel;
   logic [4:0] flag_cur;
   logic       busy;

   int checks = 0;
   int failures = 0;

   flag_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .pix_y      (pix_y),
      .btn_next   (btn_next),
      .btn_prev   (btn_prev),
      .auto_en    (auto_en),
      .flag_sel   (flag_sel),
      .flag_cur   (flag_cur),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         frame_tick = 1'b1;
         tick(1);
         frame_tick = 1'b0;
         tick(1);
      end
   endtask

   task automatic press(input logic is_next);
      if (is_next) btn_next = 1'b1; else btn_prev = 1'b1;
      tick(3);
      btn_next = 1'b0;
      btn_prev = 1'b0;
      tick(3);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      btn_next = 1'b0;
      btn_prev = 1'b0;
      frame_tick = 1'b0;
      auto_en = 1'b0;
      pix_y = 10'd0;
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (flag_sel !== 5'd0 || flag_cur !== 5'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: sel=%0d cur=%0d busy=%0b want 0 0 0", flag_sel, flag_cur, busy);
      end
   endtask

   task automatic test_held_next();
      do_reset();
      btn_next = 1'b1;
      tick(2);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL sync_latency_early: busy=%0b want 0", busy);
      end
      tick(1);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL sync_latency: busy=%0b want 1", busy);
      end
      frames(1);
      pix_y = 10'd0;
      #1;
      checks++;
      if (flag_sel !== 5'd1) begin
         failures++;
         $display("FAIL held_nxt: sel=%0d want 1", flag_sel);
      end
      frames(28);
      checks++;
      if (busy !== 1'b1 || flag_cur !== 5'd0) begin
         failures++;
         $display("FAIL wipe_29_ticks: busy=%0b cur=%0d want 1 0", busy, flag_cur);
      end
      frames(1);
      checks++;
      if (busy !== 1'b0 || flag_cur !== 5'd1) begin
         failures++;
         $display("FAIL wipe_30_ticks: busy=%0b cur=%0d want 0 1", busy, flag_cur);
      end
      frames(5);
      checks++;
      if (busy !== 1'b0 || flag_cur !== 5'd1) begin
         failures++;
         $display("FAIL held_single: busy=%0b cur=%0d want 0 1", busy, flag_cur);
      end
      btn_next = 1'b0;
      tick(3);
   endtask

   task automatic test_wrap();
      do_reset();
      press(1'b0);
      frames(1);
      checks++;
      if (flag_sel !== 5'd23) begin
         failures++;
         $display("FAIL wrap_back_nxt: sel=%0d want 23", flag_sel);
      end
      frames(29);
      checks++;
      if (flag_cur !== 5'd23 || busy !== 1'b0) begin
         failures++;
         $display("FAIL wrap_back_cur: cur=%0d busy=%0b want 23 0", flag_cur, busy);
      end
      press(1'b1);
      frames(1);
      checks++;
      if (flag_sel !== 5'd0) begin
         failures++;
         $display("FAIL wrap_fwd_nxt: sel=%0d want 0", flag_sel);
      end
      frames(29);
      checks++;
      if (flag_cur !== 5'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL wrap_fwd_cur: cur=%0d busy=%0b want 0 0", flag_cur, busy);
      end
   endtask

   task automatic test_boundary_chain();
      do_reset();
      press(1'b1);
      frames(10);
      pix_y = 10'd159;
      #1;
      checks++;
      if (flag_sel !== 5'd1) begin
         failures++;
         $display("FAIL row_159: sel=%0d want 1", flag_sel);
      end
      pix_y = 10'd160;
      #1;
      checks++;
      if (flag_sel !== 5'd0) begin
         failures++;
         $display("FAIL row_160: sel=%0d want 0", flag_sel);
      end
      pix_y = 10'd0;
      press(1'b1);
      press(1'b0);
      frames(20);
      checks++;
      if (flag_cur !== 5'd1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL chain_start: cur=%0d busy=%0b want 1 1", flag_cur, busy);
      end
      frames(1);
      checks++;
      if (flag_sel !== 5'd0) begin
         failures++;
         $display("FAIL chain_dir: sel=%0d want 0", flag_sel);
      end
      frames(29);
      checks++;
      if (flag_cur !== 5'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL chain_done: cur=%0d busy=%0b want 0 0", flag_cur, busy);
      end
   endtask

   task automatic test_auto();
      do_reset();
      auto_en = 1'b1;
      frames(179);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL auto_179: busy=%0b want 0", busy);
      end
      frames(1);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL auto_180: busy=%0b want 1", busy);
      end
      frames(30);
      checks++;
      if (flag_cur !== 5'd1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL auto_done: cur=%0d busy=%0b want 1 0", flag_cur, busy);
      end
      frames(179);
      btn_next = 1'b1;
      tick(2);
      frame_tick = 1'b1;
      tick(1);
      frame_tick = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL auto_btn_start: busy=%0b want 1", busy);
      end
      btn_next = 1'b0;
      frames(1);
      checks++;
      if (flag_sel !== 5'd2) begin
         failures++;
         $display("FAIL auto_btn_nxt: sel=%0d want 2", flag_sel);
      end
      frames(29);
      checks++;
      if (flag_cur !== 5'd2 || busy !== 1'b0) begin
         failures++;
         $display("FAIL auto_btn_done: cur=%0d busy=%0b want 2 0", flag_cur, busy);
      end
      auto_en = 1'b0;
      frames(500);
      checks++;
      if (flag_cur !== 5'd2 || busy !== 1'b0) begin
         failures++;
         $display("FAIL auto_off: cur=%0d busy=%0b want 2 0", flag_cur, busy);
      end
   endtask

   task automatic test_both_buttons();
      do_reset();
      btn_next = 1'b1;
      btn_prev = 1'b1;
      tick(3);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL both_busy: busy=%0b want 0", busy);
      end
      btn_next = 1'b0;
      btn_prev = 1'b0;
      tick(3);
      frames(2);
      checks++;
      if (flag_cur !== 5'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL both_state: cur=%0d busy=%0b want 0 0", flag_cur, busy);
      end
   endtask

   task automatic test_reset_mid_wipe();
      do_reset();
      press(1'b1);
      frames(15);
      pix_y = 10'd0;
      #1;
      checks++;
      if (flag_sel !== 5'd1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL pre_abort: sel=%0d busy=%0b want 1 1", flag_sel, busy);
      end
      rst = 1'b1;
      tick(1);
      checks++;
      if (flag_sel !== 5'd0 || flag_cur !== 5'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL abort: sel=%0d cur=%0d busy=%0b want 0 0 0", flag_sel, flag_cur, busy);
      end
      rst = 1'b0;
      frames(31);
      checks++;
      if (flag_cur !== 5'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_idle: cur=%0d busy=%0b want 0 0", flag_cur, busy);
      end
   endtask

   initial begin
      test_reset();
      test_held_next();
      test_wrap();
      test_boundary_chain();
      test_auto();
      test_both_buttons();
      test_reset_mid_wipe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
